unary_stream_encoder: RTL
=========================

// Module: unary_stream_encoder
// PURPOSE
//  Converts a binary magnitude into a serial unary bitstream of exactly INPUT_WIDTH bits containing
//  exactly in_value ones. Upstream stage of the unary arithmetic units.
//  bit_out/bit_valid drive one operand lane of a unary adder: a/ready[0] or b/ready[1].
//  Accepts one value per stream via a valid/ready handshake. A downstream hold stalls emission.
// PARAMETERS
//  INPUT_WIDTH  32                            stream length in bits; must match the consumer
//  COUNT_WIDTH  $clog2(INPUT_WIDTH+1)         width of magnitudes and counters
//  MODE         1                             0 = thermometer (ones first); 1 = evenly distributed
// PORTS
//  clk        in   1            single clock, rising edge
//  reset      in   1            asynchronous, active-low reset
//  in_value   in   COUNT_WIDTH  magnitude to encode; values > INPUT_WIDTH saturate to INPUT_WIDTH
//  in_valid   in   1            in_value is valid
//  in_ready   out  1            encoder can accept; a transfer happens when in_valid & in_ready
//  hold       in   1            downstream stall; freezes emission while high
//  bit_out    out  1            current unary bit
//  bit_valid  out  1            bit_out is a stream bit; connects to the consumer's ready lane
//  busy       out  1            stream in progress; registered copy of state == EMIT
//  done       out  1            one-cycle pulse, coincident with the last bit (bit index INPUT_WIDTH-1)
// BEHAVIOUR
//  Reset (async assert; sync deassert at the top level):
//   - state = IDLE; value_q, bit_idx and acc = 0
//   - bit_out, bit_valid, busy and done = 0
//   - A mid-stream reset abandons the stream; no done pulse is produced.
//  FSM IDLE:
//   - in_ready = 1; bit_valid = 0 at the next edge
//   - On a transfer: value_q = min(in_value, INPUT_WIDTH), bit_idx = 0, acc = 0, go to EMIT
//   - hold is ignored in IDLE.
//  FSM EMIT (each edge with hold = 0):
//   - register one bit: bit_valid = 1, bit_idx++
//   - MODE 0: bit_out = (bit_idx < value_q)
//   - MODE 1: s = acc + value_q, in COUNT_WIDTH+1 bits
//       - if s >= INPUT_WIDTH: bit_out = 1, acc = s - INPUT_WIDTH
//       - else: bit_out = 0, acc = s
//   - On the edge that emits bit_idx == INPUT_WIDTH-1: done = 1; go to IDLE unless a new transfer
//     occurs on that same edge.
//  hold = 1 in EMIT:
//   - state, bit_idx and acc are frozen; bit_valid = 0 at the next edge; bit_out keeps its value
//   - The stream resumes with no lost or duplicated bits.
//  in_ready (combinational) = (state == IDLE) | (state == EMIT & bit_idx == INPUT_WIDTH-1 & !hold)
//   - This allows back-to-back streams with no bubble.
//   - On a same-edge transfer: reload value_q, bit_idx = 0, acc = 0, stay in EMIT.
//  Latency:
//   - Transfer at edge E0 -> bit 0 is valid after E1; bit k is valid after E(k+1) when there is no hold.
//   - One stream takes exactly INPUT_WIDTH bit_valid cycles.
//  Invariant: ones per stream == value_q, in both modes.
//   - value_q = 0 gives all zeros; value_q = INPUT_WIDTH gives all ones.
//  in_value and in_valid are don't-care when in_ready = 0; the encoder does not latch them.
// STRUCTURE
//  Package unary_pkg:
//   - function count_width(int w) returning $clog2(w+1)
//   - typedef enum logic {IDLE, EMIT} enc_state_t
//   - typedef enum logic {THERMO, DISTRIB} unary_mode_t
//  No sub-module: one FSM, a bit counter and one accumulator in a single always_ff plus an always_comb.
//  The bit_idx counter is COUNT_WIDTH wide. It is compared against INPUT_WIDTH-1 and never wraps
//  past INPUT_WIDTH.
// TESTING
//  1. MODE=1, W=32, load 16, hold=0 -> bits 0,1,0,1,... ; 16 ones over 32 valid cycles;
//     done high with bit 31; in_ready high again.
//  2. MODE=0, load 5 -> bits 1 for idx 0..4 and 0 for idx 5..31.
//     Load 0 -> 32 zeros. Load 40 -> saturates to 32 ones.
//  3. Back-to-back: present 7 then 25 with in_valid held high -> 64 consecutive bit_valid cycles
//     with no bubble; ones counts 7 and 25; two done pulses.
//  4. MODE=1, load 11, hold high on random cycles (about 30%) -> exactly 32 bit_valid cycles,
//     11 ones, and a bitstream identical to the unstalled run.
//  5. Reset asserted at bit 10 of a stream -> all outputs 0 asynchronously; no done pulse;
//     after release, in_ready = 1 and the next stream is correct.
//  6. Chain two encoders into a unary adder (lanes a and b), loads 8 and 24 -> the adder
//     output stream carries 16 ones.

Source files
------------

// File: rtl/unary_stream_encoder_pkg.sv
// Shared types and helpers for the unary arithmetic datapath.
package unary_pkg;

  // Number of bits needed to hold any magnitude 0..w inclusive.
  function automatic int count_width(input int w);
    return $clog2(w + 1);
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } enc_state_t;

  typedef enum logic {
    THERMO  = 1'b0,  // ones first, then zeros
    DISTRIB = 1'b1   // ones spread evenly across the stream
  } unary_mode_t;

endpackage

// File: rtl/unary_stream_encoder.sv
// Binary-to-unary serialiser: accepts one magnitude per stream and emits exactly
// INPUT_WIDTH bits containing that many ones, with a downstream hold and
// bubble-free back-to-back streams.
module unary_stream_encoder
  import unary_pkg::*;
#(
  parameter int          INPUT_WIDTH = 32,
  parameter int          COUNT_WIDTH = count_width(INPUT_WIDTH),
  parameter unary_mode_t MODE        = DISTRIB
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [COUNT_WIDTH-1:0] in_value,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   hold,
  output logic                   bit_out,
  output logic                   bit_valid,
  output logic                   busy,
  output logic                   done
);

  localparam logic [COUNT_WIDTH-1:0] WIDTH_C    = COUNT_WIDTH'(INPUT_WIDTH);
  localparam logic [COUNT_WIDTH-1:0] LAST_IDX_C = COUNT_WIDTH'(INPUT_WIDTH - 1);
  localparam logic [COUNT_WIDTH:0]   WIDTH_EXT_C = {1'b0, WIDTH_C};

  enc_state_t             state_q, state_d;
  logic [COUNT_WIDTH-1:0] value_q, value_d;
  logic [COUNT_WIDTH-1:0] bit_idx_q, bit_idx_d;
  logic [COUNT_WIDTH-1:0] acc_q, acc_d;
  logic                   bit_out_q, bit_out_d;
  logic                   bit_valid_q, bit_valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   last_s;
  logic                   transfer_s;
  logic [COUNT_WIDTH-1:0] sat_value_s;
  logic [COUNT_WIDTH:0]   sum_s;
  logic [COUNT_WIDTH:0]   wrap_s;

  // Handshake and datapath helpers; the ready path lets a new value load on the last-bit edge.
  assign last_s      = (bit_idx_q == LAST_IDX_C);
  assign in_ready    = (state_q == IDLE) | ((state_q == EMIT) & last_s & ~hold);
  assign transfer_s  = in_valid & in_ready;
  assign sat_value_s = (in_value > WIDTH_C) ? WIDTH_C : in_value;
  assign sum_s       = {1'b0, acc_q} + {1'b0, value_q};
  assign wrap_s      = sum_s - WIDTH_EXT_C;

  // Next-state and next-output logic for the IDLE/EMIT controller.
  always_comb begin
    state_d     = state_q;
    value_d     = value_q;
    bit_idx_d   = bit_idx_q;
    acc_d       = acc_q;
    bit_out_d   = bit_out_q;
    bit_valid_d = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (transfer_s) begin
          value_d   = sat_value_s;
          bit_idx_d = '0;
          acc_d     = '0;
          state_d   = EMIT;
        end else begin
          state_d   = IDLE;
        end
      end

      EMIT: begin
        if (!hold) begin
          bit_valid_d = 1'b1;
          if (MODE == THERMO) begin
            bit_out_d = (bit_idx_q < value_q);
          end else if (sum_s >= WIDTH_EXT_C) begin
            // Accumulator overflow marks where a one falls in the spread pattern.
            bit_out_d = 1'b1;
            acc_d     = wrap_s[COUNT_WIDTH-1:0];
          end else begin
            bit_out_d = 1'b0;
            acc_d     = sum_s[COUNT_WIDTH-1:0];
          end

          if (last_s) begin
            done_d    = 1'b1;
            bit_idx_d = '0;
            if (transfer_s) begin
              value_d = sat_value_s;
              acc_d   = '0;
              state_d = EMIT;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          // Stalled: everything frozen, bit_out keeps its last value.
          state_d = EMIT;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == EMIT);
  end

  // State and registered-output flops; a reset mid-stream simply abandons it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      value_q     <= '0;
      bit_idx_q   <= '0;
      acc_q       <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      value_q     <= value_d;
      bit_idx_q   <= bit_idx_d;
      acc_q       <= acc_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
